// File: rtl/quick_spi_slave_if.sv
// quick_spi_slave_if: SPI pins plus the local transmit/receive
// port of the quick_spi target, bundled with master/slave views.
interface quick_spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sclk;
    logic                  ss_n;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  underrun;
    logic                  overrun;
    logic                  busy;

    modport slave (
        input  sclk, ss_n, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid,
        output underrun, overrun, busy
    );

    modport master (
        output sclk, ss_n, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid,
        input  underrun, overrun, busy
    );
endinterface

// File: rtl/quick_spi_slave.sv
// quick_spi_slave: SPI target that oversamples sclk/ss_n/mosi in
// the clk domain, with a one-word transmit holding register.
module quick_spi_slave #(
    parameter int                    DATA_WIDTH = 8,
    parameter bit                    CPOL       = 1'b0,
    parameter bit                    CPHA       = 1'b0,
    parameter bit                    MSB_FIRST  = 1'b1,
    parameter logic [DATA_WIDTH-1:0] IDLE_TX    = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    quick_spi_slave_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t state;

    logic sclk_s1, sclk_s2, sclk_h;
    logic ss_s1, ss_s2, ss_h;
    logic mosi_s1, mosi_s2;

    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_empty;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [CW-1:0]         cnt;

    logic                  sdo;
    logic                  sdo_en;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  rx_pulse;
    logic                  urun;
    logic                  orun;
    logic                  active;

    logic                  lead;
    logic                  trail;
    logic                  smp_edge;
    logic                  shf_edge;
    logic                  ss_fall;
    logic                  ss_rise;
    logic                  tx_load;
    logic                  last_bit;
    logic [DATA_WIDTH-1:0] next_word;
    logic [DATA_WIDTH-1:0] rx_next;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(
        input logic [DATA_WIDTH-1:0] w
    );
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign lead     = (sclk_s2 != CPOL) && (sclk_h == CPOL);
    assign trail    = (sclk_s2 == CPOL) && (sclk_h != CPOL);
    assign smp_edge = CPHA ? trail : lead;
    assign shf_edge = CPHA ? lead : trail;
    assign ss_fall  = !ss_s2 && ss_h;
    assign ss_rise  = ss_s2 && !ss_h;
    assign tx_load  = bus.tx_valid && hold_empty;
    assign last_bit = (cnt == CW'(DATA_WIDTH - 1));

    // An empty holding register hands over the idle pattern instead
    assign next_word = hold_empty ? IDLE_TX : hold_data;

    assign rx_next = MSB_FIRST
        ? {rx_shift[DATA_WIDTH-2:0], mosi_s2}
        : {mosi_s2, rx_shift[DATA_WIDTH-1:1]};

    assign bus.miso     = sdo;
    assign bus.miso_oe  = sdo_en;
    assign bus.tx_ready = hold_empty;
    assign bus.rx_data  = rx_word;
    assign bus.rx_valid = rx_pulse;
    assign bus.underrun = urun;
    assign bus.overrun  = orun;
    assign bus.busy     = active;

    // Two-flop synchronisers plus a history flop for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_s1 <= CPOL;
            sclk_s2 <= CPOL;
            sclk_h  <= CPOL;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_h    <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
        end else begin
            sclk_s1 <= bus.sclk;
            sclk_s2 <= sclk_s1;
            sclk_h  <= sclk_s2;
            ss_s1   <= bus.ss_n;
            ss_s2   <= ss_s1;
            ss_h    <= ss_s2;
            mosi_s1 <= bus.mosi;
            mosi_s2 <= mosi_s1;
        end
    end

    // Transfer FSM: holding register, shifters, counter and outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            hold_data  <= '0;
            hold_empty <= 1'b1;
            tx_shift   <= '0;
            rx_shift   <= '0;
            cnt        <= '0;
            sdo        <= 1'b0;
            sdo_en     <= 1'b0;
            rx_word    <= '0;
            rx_pulse   <= 1'b0;
            urun       <= 1'b0;
            orun       <= 1'b0;
            active     <= 1'b0;
        end else begin
            rx_pulse <= 1'b0;
            urun     <= 1'b0;
            orun     <= 1'b0;

            // A same-cycle transfer below still sees the old content
            if (tx_load) begin
                hold_data  <= bus.tx_data;
                hold_empty <= 1'b0;
            end

            unique case (state)
                S_IDLE: begin
                    if (ss_fall) begin
                        state  <= S_ACTIVE;
                        active <= 1'b1;
                        sdo_en <= 1'b1;
                        cnt    <= '0;
                        urun   <= hold_empty;
                        if (!hold_empty) begin
                            hold_empty <= 1'b1;
                        end
                        if (!CPHA) begin
                            sdo      <= first_bit(next_word);
                            tx_shift <= advance(next_word);
                        end else begin
                            tx_shift <= next_word;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (ss_rise) begin
                        state  <= S_IDLE;
                        active <= 1'b0;
                        sdo_en <= 1'b0;
                        sdo    <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        if (smp_edge) begin
                            rx_shift <= rx_next;
                            if (last_bit) begin
                                cnt      <= '0;
                                rx_word  <= rx_next;
                                rx_pulse <= 1'b1;
                                orun     <= rx_pulse;
                                tx_shift <= next_word;
                                urun     <= hold_empty;
                                if (!hold_empty) begin
                                    hold_empty <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + CW'(1);
                            end
                        end
                        if (shf_edge) begin
                            sdo      <= first_bit(tx_shift);
                            tx_shift <= advance(tx_shift);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/quick_spi_slave.md
Name: quick_spi_slave

Overview:
SPI responder: the target-side counterpart of the quick_spi master. It oversamples sclk, ss_n and mosi in the system clk domain and deserialises mosi into parallel words. It serialises a preloaded transmit word onto miso. It sits behind the target chip-select pin and provides a valid/ready transmit port and a pulsed receive port to local logic.

Parameters:
DATA_WIDTH, 8, bits per SPI word
CPOL, 0, sclk idle level
CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge
MSB_FIRST, 1, 1 = MSB shifted first; 0 = LSB shifted first
IDLE_TX, all-ones, word sent when no tx word is loaded (underrun)

Ports:
clk  in  1  system clock; must be at least 8x the sclk frequency
rst_n  in  1  reset, synchronous, active-low
sclk  in  1  SPI clock, asynchronous to clk
ss_n  in  1  chip select, active-low, asynchronous
mosi  in  1  serial data from the master
miso  out  1  serial data to the master
miso_oe  out  1  miso output enable; high only while selected
tx_data  in  DATA_WIDTH  next word to transmit
tx_valid  in  1  tx_data is valid
tx_ready  out  1  transmit holding register is empty
rx_data  out  DATA_WIDTH  last completed received word
rx_valid  out  1  one-cycle pulse when rx_data updates
underrun  out  1  one-cycle pulse when IDLE_TX was loaded because the holding register was empty
overrun  out  1  one-cycle pulse when a received word completes while rx_valid is high (back-to-back, same cycle)
busy  out  1  high in ACTIVE state

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, underrun=0, overrun=0, busy=0. Reset also clears the holding register, shift registers and bit counter; synchroniser flops reset to idle (sclk=CPOL, ss_n=1).
- Synchronisers: two flops each on sclk, ss_n and mosi, plus one history flop for edge detection. Input-to-internal-event latency is 3 clk.
- Edge definitions: leading edge = sclk transitions away from CPOL; trailing edge = sclk transitions back to CPOL. Sample edge is leading if CPHA=0, trailing if CPHA=1. Shift edge is the other one.
- Holding register: loads when tx_valid && tx_ready; tx_ready then drops. The register empties when it transfers into the shift register. tx_valid while tx_ready=0 is ignored (no overwrite).
- FSM states:
  - IDLE: on synced ss_n falling, go to ACTIVE. Load the tx shift register from the holding register (or IDLE_TX plus an underrun pulse). Clear the bit counter; set miso_oe=1.
    - CPHA=0: drive the first bit on miso the same cycle.
    - CPHA=1: drive the first bit on the first leading edge.
  - ACTIVE:
    - Sample edge: shift the synced mosi into the rx shift register and increment the bit counter.
    - Shift edge: present the next tx bit on miso.
    - When the counter reaches DATA_WIDTH on a sample edge: rx_data <= assembled word; rx_valid=1 for 1 clk; counter <= 0; reload the tx shift register (holding register or IDLE_TX plus underrun) for the next word without deasserting ss_n.
    - CPHA=0 word boundary: the next word's first bit is driven on the trailing edge after the last sample.
  - Synced ss_n rising in any state: return to IDLE next cycle; miso_oe=0; miso=0.
    - A partial word is discarded: no rx_valid, counter cleared.
    - An unconsumed tx word loaded into the shift register is lost; the holding register is kept.
- Bit order per MSB_FIRST applies to both directions.
- Simultaneous events:
  - Holding-register load and transfer in the same cycle: the transfer takes the old content (empty means IDLE_TX) and the new word loads into the holding register.
  - ss_n rise coincident with a sample edge: the ss_n rise wins and the edge is ignored.
- Synchronous reset mid-transfer: immediate return to reset values. The slave rejoins only on the next ss_n falling edge.

Test Plan:
- Mode 0, MSB first: preload tx 0xA5; master sends 0x6A -> rx_data=0x6A with one rx_valid pulse; miso bit stream 1,0,1,0,0,1,0,1; tx_ready returns to 1 at ss_n fall.
- No preload: master sends 0x5A -> miso shifts 0xFF, underrun pulses once, rx_data=0x5A.
- Back-to-back under one ss_n: holding loaded with 0x11, then 0x22 after tx_ready rises; master sends 0x95, 0x3C -> two rx_valid pulses (0x95, 0x3C); miso carries 0x11 then 0x22.
- Abort: ss_n deasserted after 5 bits -> no rx_valid, miso_oe falls, next full transfer of 0xC3 receives correctly.
- CPHA=1, CPOL=1, LSB first: master sends 0x01 with tx 0x80 -> rx_data=0x01; first miso bit 0 driven on the first falling sclk.
- Reset asserted mid-word -> all outputs at reset values next cycle; a subsequent transfer of 0xE7 completes correctly.
